// File: rtl/freq_meter_if.sv
// freq_meter_if: signal bundle between the test-signal source/control side
// (master) and the frequency meter (slave).
//   sigin   : signal under test, asynchronous to sysclk
//   en      : measurement enable
//   mode    : 0 = gate (edge count), 1 = period (sysclk cycles per period)
//   result  : last completed measurement
//   valid   : one-cycle strobe, result/ovf/timeout change in that cycle
//   ovf     : gate-mode edge count saturated in the reported window
//   timeout : period mode saw no edge for the timeout limit
//   busy    : meter is measuring (not idle)
// CNT_W must match the CNT_W of the freq_meter instance it connects to.
interface freq_meter_if #(
  parameter int CNT_W = 32
);
  logic             sigin;
  logic             en;
  logic             mode;
  logic [CNT_W-1:0] result;
  logic             valid;
  logic             ovf;
  logic             timeout;
  logic             busy;

  modport master (
    output sigin, en, mode,
    input  result, valid, ovf, timeout, busy
  );

  modport slave (
    input  sigin, en, mode,
    output result, valid, ovf, timeout, busy
  );
endinterface

// File: rtl/freq_meter.sv
// freq_meter: measures a square wave in one of two runtime-selected modes.
//   gate mode   : rising edges counted over back-to-back GATE_CYCLES windows
//   period mode : sysclk cycles between consecutive rising edges
// Ports:
//   sysclk : system clock
//   rst    : asynchronous active-low reset
//   bus    : freq_meter_if slave (sigin/en/mode in; result/valid/ovf/timeout/busy out)
// A one-cycle valid accompanies every completed measurement; result, ovf and
// timeout hold their last value otherwise.
module freq_meter #(
  parameter int CNT_W          = 32,
  parameter int GATE_CYCLES    = 100000000,
  parameter int TIMEOUT_CYCLES = 200000000
) (
  input  logic        sysclk,
  input  logic        rst,
  freq_meter_if.slave bus
);

  localparam int GW = (GATE_CYCLES > 1) ? $clog2(GATE_CYCLES) : 1;
  // Period/wait counters must reach TIMEOUT_CYCLES itself.
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  localparam logic [GW-1:0]    GATE_LAST = GW'(GATE_CYCLES - 1);
  localparam logic [TW-1:0]    WAIT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [TW-1:0]    PER_LIMIT = TW'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, GATE, WAIT_EDGE, PERIOD} state_t;

  state_t           state, state_d;
  logic [2:0]       sync_q;      // [0]=s1, [1]=s2, [2]=s3 (edge delay)
  logic             sig_edge;
  logic             mode_q;
  logic             restart;
  logic [GW-1:0]    gate_cnt;
  logic [CNT_W-1:0] edge_cnt, edge_cnt_nx;
  logic             sat, sat_hit;
  logic [TW-1:0]    wait_cnt, per_cnt;
  logic             per_to;
  logic [CNT_W-1:0] result_q;
  logic             valid_q, ovf_q, timeout_q;

  // Synchronizer plus delay flop; s3 resets low so a high input at reset
  // release still produces exactly one edge.
  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) sync_q <= '0;
    else      sync_q <= {sync_q[1:0], bus.sigin};
  end

  assign sig_edge = sync_q[1] & ~sync_q[2];

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) mode_q <= 1'b0;
    else      mode_q <= bus.mode;
  end

  // A mode change or dropped enable aborts whatever is in flight, even a
  // measurement completing in the same cycle.
  assign restart = ~bus.en | (bus.mode != mode_q);

  // Saturating edge accumulator for gate mode.
  always_comb begin
    sat_hit     = sig_edge && (edge_cnt == CNT_MAX);
    edge_cnt_nx = edge_cnt;
    if (sig_edge && !sat_hit) edge_cnt_nx = edge_cnt + CNT_W'(1);
  end

  assign per_to = (per_cnt == PER_LIMIT) && !sig_edge;

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (restart) begin
      state_d = IDLE;
    end else begin
      case (state)
        IDLE:      state_d = mode_q ? WAIT_EDGE : GATE;
        GATE:      state_d = GATE;
        WAIT_EDGE: if (sig_edge) state_d = PERIOD;
        PERIOD:    if (per_to)   state_d = WAIT_EDGE;
        default:   state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge sysclk or negedge rst) begin
    if (!rst) begin
      gate_cnt  <= '0;
      edge_cnt  <= '0;
      sat       <= 1'b0;
      wait_cnt  <= '0;
      per_cnt   <= '0;
      result_q  <= '0;
      valid_q   <= 1'b0;
      ovf_q     <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      valid_q <= 1'b0;
      if (restart || state == IDLE) begin
        gate_cnt <= '0;
        edge_cnt <= '0;
        sat      <= 1'b0;
        wait_cnt <= '0;
        per_cnt  <= '0;
      end else begin
        case (state)
          GATE: begin
            // Last window cycle still counts its own edge; the next window
            // starts on the following cycle with no gap.
            if (gate_cnt == GATE_LAST) begin
              result_q  <= edge_cnt_nx;
              ovf_q     <= sat | sat_hit;
              timeout_q <= 1'b0;
              valid_q   <= 1'b1;
              gate_cnt  <= '0;
              edge_cnt  <= '0;
              sat       <= 1'b0;
            end else begin
              gate_cnt <= gate_cnt + GW'(1);
              edge_cnt <= edge_cnt_nx;
              sat      <= sat | sat_hit;
            end
          end
          WAIT_EDGE: begin
            if (sig_edge) begin
              per_cnt  <= TW'(1);
              wait_cnt <= '0;
            end else if (wait_cnt == WAIT_LAST) begin
              result_q  <= '0;
              ovf_q     <= 1'b0;
              timeout_q <= 1'b1;
              valid_q   <= 1'b1;
              wait_cnt  <= '0;
            end else begin
              wait_cnt <= wait_cnt + TW'(1);
            end
          end
          PERIOD: begin
            // per_cnt equals cycles since the previous edge, so the value
            // seen on an edge is the input period exactly.
            if (sig_edge) begin
              result_q  <= CNT_W'(per_cnt);
              ovf_q     <= 1'b0;
              timeout_q <= 1'b0;
              valid_q   <= 1'b1;
              per_cnt   <= TW'(1);
            end else if (per_cnt == PER_LIMIT) begin
              result_q  <= '0;
              ovf_q     <= 1'b0;
              timeout_q <= 1'b1;
              valid_q   <= 1'b1;
              per_cnt   <= '0;
              wait_cnt  <= '0;
            end else begin
              per_cnt <= per_cnt + TW'(1);
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign bus.result  = result_q;
  assign bus.valid   = valid_q;
  assign bus.ovf     = ovf_q;
  assign bus.timeout = timeout_q;
  assign bus.busy    = (state != IDLE);

endmodule

// File: tb/tb_freq_meter.sv
// tb_freq_meter: randomized bench for freq_meter. dut_a is a 32-bit meter
// with short gate/timeout limits, dut_b a 4-bit meter for saturation.
// Reference model: the bench logs the sysclk index at which each rising edge
// of sigin is first sampled; an edge is counted by the meter two cycles later.
// Gate results are the logged edges falling inside the window ending at the
// valid cycle, period results the spacing of the two latest logged edges.
module tb_freq_meter;
  localparam int G_A = 3200;
  localparam int T_A = 5000;
  localparam int G_B = 400;
  localparam int T_B = 5000;

  logic sysclk = 1'b0;
  logic rst    = 1'b0;
  logic sig    = 1'b0;
  logic en_a = 1'b0, mode_a = 1'b0, en_b = 1'b0, mode_b = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  int   rq[$];

  always #5 sysclk = ~sysclk;
  always @(posedge sysclk) cyc <= cyc + 1;

  freq_meter_if #(.CNT_W(32)) ia ();
  freq_meter_if #(.CNT_W(4))  ib ();

  assign ia.sigin = sig;
  assign ia.en    = en_a;
  assign ia.mode  = mode_a;
  assign ib.sigin = sig;
  assign ib.en    = en_b;
  assign ib.mode  = mode_b;

  freq_meter #(.CNT_W(32), .GATE_CYCLES(G_A), .TIMEOUT_CYCLES(T_A)) dut_a (
    .sysclk(sysclk), .rst(rst), .bus(ia)
  );
  freq_meter #(.CNT_W(4), .GATE_CYCLES(G_B), .TIMEOUT_CYCLES(T_B)) dut_b (
    .sysclk(sysclk), .rst(rst), .bus(ib)
  );

  // ---------------- reference model ----------------
  function automatic int exp_gate(input int d, input int g);
    int n = 0;
    foreach (rq[i]) if (rq[i] + 2 > d - g && rq[i] + 2 <= d) n++;
    return n;
  endfunction

  function automatic int exp_period(input int d);
    for (int i = 1; i < rq.size(); i++)
      if (rq[i] + 2 == d) return rq[i] - rq[i-1];
    return -1;
  endfunction

  function automatic int n_consumed(input int d);
    int n = 0;
    foreach (rq[i]) if (rq[i] + 2 <= d) n++;
    return n;
  endfunction

  // One cycle: outputs observed at this negedge reflect posedge 'cyc';
  // the new sigin level is first sampled at posedge cyc+1.
  task automatic step(input logic v);
    @(negedge sysclk);
    if (v && !sig) rq.push_back(cyc + 1);
    sig = v;
  endtask

  task automatic quiesce();
    en_a = 1'b0; en_b = 1'b0; mode_a = 1'b0; mode_b = 1'b0;
    repeat (4) step(1'b0);
    rq.delete();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge sysclk);
    checks++; if (ia.result !== 32'd0) begin errors++; $display("FAIL reset_result: got %0d want 0", ia.result); end
    checks++; if (ia.valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b want 0", ia.valid); end
    checks++; if (ia.ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b want 0", ia.ovf); end
    checks++; if (ia.timeout !== 1'b0) begin errors++; $display("FAIL reset_timeout: got %b want 0", ia.timeout); end
    checks++; if (ia.busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", ia.busy); end
    checks++; if (ib.valid !== 1'b0 || ib.result !== 4'd0) begin errors++; $display("FAIL reset_b: got valid %b result %0d want 0 0", ib.valid, ib.result); end
    rst = 1'b1;
  endtask

  task automatic test_gate(input bit jitter, input int p);
    int seg, nv = 0, last = 0, first, et, e;
    logic v;
    quiesce();
    en_a = 1'b1;
    first = cyc + 1 + G_A;
    v = 1'($urandom_range(0, 1));
    seg = jitter ? 1 : int'($urandom_range(1, p / 2));
    repeat (2 * G_A + 20) begin
      if (seg == 0) begin v = ~v; seg = jitter ? int'($urandom_range(2, 40)) : p / 2; end
      seg--;
      step(v);
      if (ia.valid) begin
        nv++;
        e = exp_gate(cyc, G_A);
        checks++;
        if (ia.result !== 32'(e) || ia.ovf !== 1'b0 || ia.timeout !== 1'b0) begin
          errors++; $display("FAIL gate_result: got %0d ovf %b to %b want %0d 0 0", ia.result, ia.ovf, ia.timeout, e);
        end
        et = (nv == 1) ? first : last + G_A;
        checks++;
        if (cyc !== et) begin errors++; $display("FAIL gate_timing: valid at %0d want %0d", cyc, et); end
        if (!jitter) begin
          checks++;
          if (ia.result !== 32'(G_A / p)) begin errors++; $display("FAIL gate_count: got %0d want %0d", ia.result, G_A / p); end
        end
        last = cyc;
      end
    end
    checks++;
    if (nv !== 2) begin errors++; $display("FAIL gate_nvalid: got %0d want 2", nv); end
  endtask

  task automatic test_ovf(input int p);
    int seg, nv = 0, e, er, first;
    logic v, eo;
    quiesce();
    en_b = 1'b1;
    first = cyc + 1 + G_B;
    v = 1'b0;
    seg = int'($urandom_range(1, p / 2));
    repeat (2 * G_B + 20) begin
      if (seg == 0) begin v = ~v; seg = p / 2; end
      seg--;
      step(v);
      if (ib.valid) begin
        nv++;
        e  = exp_gate(cyc, G_B);
        er = (e > 15) ? 15 : e;
        eo = (e > 15);
        checks++;
        if (ib.result !== 4'(er) || ib.ovf !== eo || ib.timeout !== 1'b0) begin
          errors++; $display("FAIL ovf_result: got %0d ovf %b want %0d %b (edges %0d)", ib.result, ib.ovf, er, eo, e);
        end
        checks++;
        if (cyc !== first + (nv - 1) * G_B) begin errors++; $display("FAIL ovf_timing: valid at %0d want %0d", cyc, first + (nv - 1) * G_B); end
        if (p == 8) begin
          checks++;
          if (ib.result !== 4'd15 || ib.ovf !== 1'b1) begin errors++; $display("FAIL ovf_sat: got %0d %b want 15 1", ib.result, ib.ovf); end
        end
      end
    end
    checks++;
    if (nv !== 2) begin errors++; $display("FAIL ovf_nvalid: got %0d want 2", nv); end
  endtask

  task automatic test_period(input bit jitter, input int p, input int n);
    int seg = 10, nv = 0, e, nc;
    logic v = 1'b0;
    quiesce();
    mode_a = 1'b1; en_a = 1'b1;
    repeat (n) begin
      if (seg == 0) begin v = ~v; seg = jitter ? int'($urandom_range(2, 300)) : p / 2; end
      seg--;
      step(v);
      if (ia.valid) begin
        nv++;
        e = exp_period(cyc);
        checks++;
        if (e < 0 || ia.result !== 32'(e) || ia.timeout !== 1'b0 || ia.ovf !== 1'b0) begin
          errors++; $display("FAIL period_result: got %0d to %b at %0d want %0d", ia.result, ia.timeout, cyc, e);
        end
        if (!jitter) begin
          checks++;
          if (ia.result !== 32'(p)) begin errors++; $display("FAIL period_exact: got %0d want %0d", ia.result, p); end
        end
      end
    end
    nc = n_consumed(cyc);
    checks++;
    if (nv !== nc - 1) begin errors++; $display("FAIL period_nvalid: got %0d want %0d", nv, nc - 1); end
  endtask

  task automatic test_timeout();
    int nv = 0, first, seg, nc, lastc, tgt;
    logic v;
    quiesce();
    mode_a = 1'b1;
    repeat (2) step(1'b0);
    en_a = 1'b1;
    first = cyc + 1 + T_A;
    repeat (2 * T_A + 20) begin
      step(1'b0);
      if (ia.valid) begin
        nv++;
        checks++;
        if (ia.result !== 32'd0 || ia.timeout !== 1'b1 || ia.ovf !== 1'b0 || cyc !== first + (nv - 1) * T_A) begin
          errors++; $display("FAIL wait_timeout: got %0d to %b at %0d want 0 1 at %0d", ia.result, ia.timeout, cyc, first + (nv - 1) * T_A);
        end
      end
    end
    checks++;
    if (nv !== 2) begin errors++; $display("FAIL wait_timeout_n: got %0d want 2", nv); end
    // period-8 wave after the timeouts
    nv = 0; v = 1'b0; seg = 3;
    repeat (200) begin
      if (seg == 0) begin v = ~v; seg = 4; end
      seg--;
      step(v);
      if (ia.valid) begin
        nv++;
        checks++;
        if (ia.result !== 32'd8 || ia.timeout !== 1'b0 || exp_period(cyc) !== 8) begin
          errors++; $display("FAIL recover_period: got %0d to %b want 8 0", ia.result, ia.timeout);
        end
      end
    end
    nc = n_consumed(cyc);
    checks++;
    if (nv !== nc - 1) begin errors++; $display("FAIL recover_n: got %0d want %0d", nv, nc - 1); end
    // wave stops: PERIOD state times out exactly TIMEOUT_CYCLES after last edge
    lastc = rq[rq.size() - 1] + 2;
    tgt = lastc + T_A;
    nv = 0;
    repeat (T_A + 50) begin
      step(1'b0);
      if (ia.valid) begin
        nv++;
        checks++;
        if (cyc !== tgt || ia.result !== 32'd0 || ia.timeout !== 1'b1) begin
          errors++; $display("FAIL period_timeout: got %0d to %b at %0d want 0 1 at %0d", ia.result, ia.timeout, cyc, tgt);
        end
      end
    end
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL period_timeout_n: got %0d want 1", nv); end
  endtask

  task automatic test_mode_en();
    int seg, nv = 0, bad = 0, first, r0;
    logic v;
    quiesce();
    en_a = 1'b1;
    v = 1'b0;
    seg = int'($urandom_range(1, 16));
    repeat (G_A + 10) begin
      if (seg == 0) begin v = ~v; seg = 16; end
      seg--;
      step(v);
    end
    r0 = int'(ia.result);
    checks++;
    if (r0 !== 100) begin errors++; $display("FAIL mode_en_prior: got %0d want 100", r0); end
    for (int k = 0; k < 716; k++) begin
      if (k == 700) mode_a = 1'b1;
      if (k == 703) mode_a = 1'b0;
      if (k == 706) en_a = 1'b0;
      if (seg == 0) begin v = ~v; seg = 16; end
      seg--;
      step(v);
      if (ia.valid || ia.result !== 32'(r0)) bad++;
    end
    checks++;
    if (bad !== 0) begin errors++; $display("FAIL mode_en_hold: %0d bad cycles want 0", bad); end
    checks++;
    if (ia.busy !== 1'b0) begin errors++; $display("FAIL mode_en_busy: got %b want 0", ia.busy); end
    en_a = 1'b1;
    first = cyc + 1 + G_A;
    repeat (G_A + 20) begin
      if (seg == 0) begin v = ~v; seg = 16; end
      seg--;
      step(v);
      if (ia.valid) begin
        nv++;
        checks++;
        if (cyc !== first || ia.result !== 32'(exp_gate(cyc, G_A)) || ia.result !== 32'd100) begin
          errors++; $display("FAIL mode_en_restart: got %0d at %0d want 100 at %0d", ia.result, cyc, first);
        end
      end
    end
    checks++;
    if (nv !== 1) begin errors++; $display("FAIL mode_en_n: got %0d want 1", nv); end
  endtask

  task automatic test_reset_mid();
    int seg = 10, nv = 0, nc, k;
    logic v = 1'b0, prev;
    quiesce();
    mode_a = 1'b1;
    repeat (2) step(1'b0);
    en_a = 1'b1;
    repeat (300) begin
      if (seg == 0) begin v = ~v; seg = 20; end
      seg--;
      step(v);
    end
    // advance to the cycle sigin falls, then reset mid-period
    k = 0;
    do begin
      prev = sig;
      if (seg == 0) begin v = ~v; seg = 20; end
      seg--;
      step(v);
      k++;
    end while (!(prev && !sig) && k < 50);
    rst = 1'b0;
    #1;
    checks++;
    if (ia.result !== 32'd0 || ia.valid !== 1'b0 || ia.busy !== 1'b0) begin
      errors++; $display("FAIL reset_mid: got result %0d valid %b busy %b want 0 0 0", ia.result, ia.valid, ia.busy);
    end
    rq.delete();
    repeat (3) begin
      if (seg == 0) begin v = ~v; seg = 20; end
      seg--;
      step(v);
    end
    rst = 1'b1;
    repeat (300) begin
      if (seg == 0) begin v = ~v; seg = 20; end
      seg--;
      step(v);
      if (ia.valid) begin
        nv++;
        checks++;
        if (ia.result !== 32'd40 || exp_period(cyc) !== 40 || ia.timeout !== 1'b0) begin
          errors++; $display("FAIL reset_mid_period: got %0d want 40", ia.result);
        end
      end
    end
    nc = n_consumed(cyc);
    checks++;
    if (nv !== nc - 1 || nv < 3) begin errors++; $display("FAIL reset_mid_n: got %0d want %0d", nv, nc - 1); end
  endtask

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_gate(1'b0, 32);
    test_gate(1'b1, 0);
    test_ovf(8);
    test_ovf(26);
    test_ovf(80);
    test_period(1'b0, 2000, 8500);
    test_period(1'b1, 0, 8000);
    test_timeout();
    test_mode_en();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
